filter_bank_2018: RTL

FILTER_BANK_2018 -- requirements
Module: filter_bank_2018

---
 rtl/filter_bank_2018.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/filter_bank_2018.sv
// filter_bank_2018: NUM_CH moving-average filters over one shared ADC stream.
// Ports: clk, reset (async, active low), input_data/input_valid,
//   cfg_we/cfg_ch/cfg_log2_len (per-channel window), out_sel,
//   output_data_all/output_valid_all, output_data/output_valid (selected),
//   peak_clr/peak_data (peak hold, built only with FILTER_BANK_PEAK_EN).
module filter_bank_2018 #(
  parameter int SIZE_ADC_DATA    = 12,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int NUM_CH           = 4,
  parameter int MAX_LOG2_LEN     = 5,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(MAX_LOG2_LEN + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SIZE_ADC_DATA-1:0]           input_data,
  input  logic                               input_valid,
  input  logic                               cfg_we,
  input  logic [CW-1:0]                      cfg_ch,
  input  logic [LW-1:0]                      cfg_log2_len,
  input  logic [CW-1:0]                      out_sel,
  output logic [NUM_CH*SIZE_FILTER_DATA-1:0] output_data_all,
  output logic [NUM_CH-1:0]                  output_valid_all,
  output logic [SIZE_FILTER_DATA-1:0]        output_data,
  output logic                               output_valid,
  input  logic                               peak_clr,
  output logic [SIZE_FILTER_DATA-1:0]        peak_data
);

  localparam int PW    = MAX_LOG2_LEN;
  localparam int DEPTH = 1 << PW;
  localparam int AW    = SIZE_ADC_DATA + PW;
  localparam int W     = SIZE_FILTER_DATA;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [LW-1:0] cfg_len;
  assign cfg_len = (cfg_log2_len > LW'(MAX_LOG2_LEN))
                 ? LW'(MAX_LOG2_LEN) : cfg_log2_len;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e                   st_q, st_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [PW-1:0]            fill_q, fill_d;
    logic [LW-1:0]            len_q, len_d;
    logic [W-1:0]             dat_q, dat_d;
    logic                     vld_q, vld_d;
    logic                     cfg_hit;
    logic                     accept;
    logic [PW:0]              span;
    logic [PW-1:0]            rd_addr;
    logic [PW-1:0]            len_m1;
    logic [AW-1:0]            shifted;
    logic [SIZE_ADC_DATA-1:0] mem_q [DEPTH];

    assign cfg_hit = cfg_we && (cfg_ch == CW'(k));
    assign accept  = input_valid && !cfg_hit;
    assign span    = (PW+1)'(1) << len_q;
    // Window of 2^MAX wraps onto the slot being overwritten.
    assign rd_addr = ptr_q - span[PW-1:0];
    assign len_m1  = PW'(span - (PW+1)'(1));

    always_ff @(posedge clk) begin
      if (accept) mem_q[ptr_q] <= input_data;
    end

    always_comb begin
      st_d    = st_q;
      acc_d   = acc_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      len_d   = len_q;
      dat_d   = dat_q;
      vld_d   = 1'b0;
      shifted = '0;
      if (cfg_hit) begin
        len_d  = cfg_len;
        st_d   = FILL;
        acc_d  = '0;
        fill_d = '0;
      end else if (accept) begin
        ptr_d = ptr_q + 1'b1;
        unique case (st_q)
          FILL: begin
            acc_d  = acc_q + AW'(input_data);
            fill_d = fill_q + 1'b1;
            if (fill_q == len_m1) begin
              st_d  = RUN;
              vld_d = 1'b1;
            end
          end
          RUN: begin
            acc_d = acc_q + AW'(input_data)
                  - AW'(mem_q[rd_addr]);
            vld_d = 1'b1;
          end
          default: st_d = FILL;
        endcase
        shifted = acc_d >> len_q;
        if (vld_d) dat_d = W'(shifted[SIZE_ADC_DATA-1:0]);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= FILL;
        acc_q  <= '0;
        ptr_q  <= '0;
        fill_q <= '0;
        len_q  <= '0;
        dat_q  <= '0;
        vld_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        acc_q  <= acc_d;
        ptr_q  <= ptr_d;
        fill_q <= fill_d;
        len_q  <= len_d;
        dat_q  <= dat_d;
        vld_q  <= vld_d;
      end
    end

    assign output_data_all[k*W +: W] = dat_q;
    assign output_valid_all[k]       = vld_q;
  end

  logic [W-1:0] sel_dat;
  logic         sel_vld;

  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (out_sel == CW'(k)) begin
        sel_dat = output_data_all[k*W +: W];
        sel_vld = output_valid_all[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      output_data  <= '0;
      output_valid <= 1'b0;
    end else begin
      output_data  <= sel_dat;
      output_valid <= sel_vld;
    end
  end

`ifdef FILTER_BANK_PEAK_EN
  logic [W-1:0] peak_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= '0;
    end else if (output_valid && (output_data > peak_q)) begin
      peak_q <= output_data;
    end
  end

  assign peak_data = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_data       = '0;
`endif

endmodule
